wb_arbiter: RTL and testbench

Write-back arbiter that sits directly upstream of the 8x8 register file and drives its single write port (WriteEn/Waddr/DataIn). It merges two result sources into one registered write per cycle: memory load returns, which always have priority, and ALU results, which are buffered in a small FIFO. A per-register pending-load scoreboard feeds issue-stall logic and flags ALU-vs-load write hazards.

---
 rtl/wb_arbiter_if.sv | 42 ++++
 rtl/wb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU and load result sources, load-issue
// tracking and the register-file write port.
interface wb_arbiter_if #(
  parameter int W     = 8,
  parameter int A     = 3,
  parameter int DEPTH = 2
);
  localparam int N  = 1 << A;
  localparam int CW = $clog2(DEPTH + 1);

  logic          AluValid;
  logic          AluReady;
  logic [A-1:0]  AluAddr;
  logic [W-1:0]  AluData;
  logic          MemValid;
  logic [A-1:0]  MemAddr;
  logic [W-1:0]  MemData;
  logic          LdIssue;
  logic [A-1:0]  LdAddr;
  logic          WriteEn;
  logic [A-1:0]  Waddr;
  logic [W-1:0]  DataIn;
  logic [N-1:0]  Pending;
  logic [CW-1:0] AluCount;
  logic          Hazard;

  modport slave (
    input  AluValid, AluAddr, AluData,
    input  MemValid, MemAddr, MemData,
    input  LdIssue, LdAddr,
    output AluReady, WriteEn, Waddr, DataIn,
    output Pending, AluCount, Hazard
  );

  modport master (
    output AluValid, AluAddr, AluData,
    output MemValid, MemAddr, MemData,
    output LdIssue, LdAddr,
    input  AluReady, WriteEn, Waddr, DataIn,
    input  Pending, AluCount, Hazard
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: loads win, ALU results queue in a small FIFO,
// pending-load scoreboard flags ALU-vs-load hazards.
module wb_arbiter #(
  parameter int W     = 8,
  parameter int A     = 3,
  parameter int DEPTH = 2
) (
  input logic        Clk,
  input logic        Reset,
  wb_arbiter_if.slave bus
);
  localparam int N  = 1 << A;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [A-1:0]  r_amem [DEPTH];
  logic [W-1:0]  r_dmem [DEPTH];
  logic          r_we;
  logic [A-1:0]  r_waddr;
  logic [W-1:0]  r_wdata;
  logic [N-1:0]  r_pend;
  logic          r_hz;

  logic          w_rdy;
  logic          w_acc;
  logic          w_ne;
  logic          w_pop;
  logic          w_push;
  logic          w_hz;
  logic          w_we;
  logic [A-1:0]  w_wa;
  logic [W-1:0]  w_wd;
  logic [N-1:0]  w_pend;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_rdy  = (r_count < CW'(DEPTH)) && !Reset;
  assign w_acc  = bus.AluValid && w_rdy;
  assign w_ne   = (r_count != '0);
  assign w_pop  = !bus.MemValid && w_ne;
  // An accepted result bypasses the FIFO only when nothing older waits.
  assign w_push = w_acc && (bus.MemValid || w_ne);

  assign w_hz = w_acc &&
    (r_pend[bus.AluAddr] ||
     (bus.LdIssue && bus.LdAddr == bus.AluAddr));

  always_comb begin
    w_we = 1'b0;
    w_wa = r_waddr;
    w_wd = r_wdata;
    priority case (1'b1)
      bus.MemValid: begin
        w_we = 1'b1;
        w_wa = bus.MemAddr;
        w_wd = bus.MemData;
      end
      w_ne: begin
        w_we = 1'b1;
        w_wa = r_amem[r_rp];
        w_wd = r_dmem[r_rp];
      end
      w_acc: begin
        w_we = 1'b1;
        w_wa = bus.AluAddr;
        w_wd = bus.AluData;
      end
      default: ;
    endcase
  end

  // Set after clear so a new load to the same register wins.
  always_comb begin
    w_pend = r_pend;
    if (bus.MemValid) w_pend[bus.MemAddr] = 1'b0;
    if (bus.LdIssue)  w_pend[bus.LdAddr]  = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_pend  <= '0;
      r_hz    <= 1'b0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wp <= inc(r_wp);
      if (w_pop)  r_rp <= inc(r_rp);
      r_we    <= w_we;
      r_waddr <= w_wa;
      r_wdata <= w_wd;
      r_pend  <= w_pend;
      r_hz    <= w_hz;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_amem[r_wp] <= bus.AluAddr;
      r_dmem[r_wp] <= bus.AluData;
    end
  end

  assign bus.AluReady = w_rdy;
  assign bus.AluCount = r_count;
  assign bus.WriteEn  = r_we;
  assign bus.Waddr    = r_waddr;
  assign bus.DataIn   = r_wdata;
  assign bus.Pending  = r_pend;
  assign bus.Hazard   = r_hz;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter with a register-file model
// and a hand-written mid-drain reset sequence.
module tb_wb_arbiter;
  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_err;
  logic [7:0] rf [8];

  wb_arbiter_if #(.W(8), .A(3), .DEPTH(2)) bus ();

  wb_arbiter #(.W(8), .A(3), .DEPTH(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    if (bus.WriteEn) rf[bus.Waddr] <= bus.DataIn;
  end

  typedef struct {
    logic       av;
    logic [2:0] aa;
    logic [7:0] ad;
    logic       mv;
    logic [2:0] ma;
    logic [7:0] md;
    logic       li;
    logic [2:0] la;
    logic       rdy;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [7:0] pd;
    logic [1:0] cnt;
    logic       hz;
  } vec_t;

  vec_t tv [24];

  function automatic vec_t mk(
    input logic av, input logic [2:0] aa,
    input logic [7:0] ad,
    input logic mv, input logic [2:0] ma,
    input logic [7:0] md,
    input logic li, input logic [2:0] la,
    input logic rdy,
    input logic we, input logic [2:0] wa,
    input logic [7:0] wd,
    input logic [7:0] pd, input logic [1:0] cnt,
    input logic hz
  );
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md;
    v.li = li; v.la = la; v.rdy = rdy;
    v.we = we; v.wa = wa; v.wd = wd;
    v.pd = pd; v.cnt = cnt; v.hz = hz;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.AluValid = 1'b0;
    bus.AluAddr  = '0;
    bus.AluData  = '0;
    bus.MemValid = 1'b0;
    bus.MemAddr  = '0;
    bus.MemData  = '0;
    bus.LdIssue  = 1'b0;
    bus.LdAddr   = '0;
  endtask

  task automatic apply(input vec_t v, input int i);
    string s;
    bus.AluValid = v.av;
    bus.AluAddr  = v.aa;
    bus.AluData  = v.ad;
    bus.MemValid = v.mv;
    bus.MemAddr  = v.ma;
    bus.MemData  = v.md;
    bus.LdIssue  = v.li;
    bus.LdAddr   = v.la;
    #1;
    s = $sformatf("v%0d", i);
    chk({s, ".AluReady"}, 32'(bus.AluReady), 32'(v.rdy));
    @(posedge Clk);
    #1;
    chk({s, ".WriteEn"}, 32'(bus.WriteEn), 32'(v.we));
    chk({s, ".Waddr"}, 32'(bus.Waddr), 32'(v.wa));
    chk({s, ".DataIn"}, 32'(bus.DataIn), 32'(v.wd));
    chk({s, ".Pending"}, 32'(bus.Pending), 32'(v.pd));
    chk({s, ".AluCount"}, 32'(bus.AluCount), 32'(v.cnt));
    chk({s, ".Hazard"}, 32'(bus.Hazard), 32'(v.hz));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".WriteEn"}, 32'(bus.WriteEn), 0);
    chk({nm, ".Waddr"}, 32'(bus.Waddr), 0);
    chk({nm, ".DataIn"}, 32'(bus.DataIn), 0);
    chk({nm, ".Pending"}, 32'(bus.Pending), 0);
    chk({nm, ".AluCount"}, 32'(bus.AluCount), 0);
    chk({nm, ".Hazard"}, 32'(bus.Hazard), 0);
    chk({nm, ".AluReady"}, 32'(bus.AluReady), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // two ALU bypass writes
    tv[0]  = mk(1,2,22, 0,0,0,  0,0, 1, 1,2,22, 8'h00,0,0);
    tv[1]  = mk(1,3,16, 0,0,0,  0,0, 1, 1,3,16, 8'h00,0,0);
    tv[2]  = mk(0,0,0,  0,0,0,  0,0, 1, 0,3,16, 8'h00,0,0);
    // load beats ALU, ALU drains next cycle
    tv[3]  = mk(1,7,15, 1,1,8,  0,0, 1, 1,1,8,  8'h00,1,0);
    tv[4]  = mk(0,0,0,  0,0,0,  0,0, 1, 1,7,15, 8'h00,0,0);
    tv[5]  = mk(0,0,0,  0,0,0,  0,0, 1, 0,7,15, 8'h00,0,0);
    // sustained loads fill FIFO
    tv[6]  = mk(1,4,40, 1,0,1,  0,0, 1, 1,0,1,  8'h00,1,0);
    tv[7]  = mk(1,5,50, 1,1,2,  0,0, 1, 1,1,2,  8'h00,2,0);
    tv[8]  = mk(1,6,60, 1,2,3,  0,0, 0, 1,2,3,  8'h00,2,0);
    tv[9]  = mk(1,6,60, 1,3,4,  0,0, 0, 1,3,4,  8'h00,2,0);
    tv[10] = mk(1,6,60, 0,0,0,  0,0, 0, 1,4,40, 8'h00,1,0);
    tv[11] = mk(1,6,60, 0,0,0,  0,0, 1, 1,5,50, 8'h00,1,0);
    tv[12] = mk(0,0,0,  0,0,0,  0,0, 1, 1,6,60, 8'h00,0,0);
    tv[13] = mk(0,0,0,  0,0,0,  0,0, 1, 0,6,60, 8'h00,0,0);
    // pending load and hazard
    tv[14] = mk(0,0,0,  0,0,0,  1,5, 1, 0,6,60, 8'h20,0,0);
    tv[15] = mk(1,5,77, 0,0,0,  0,0, 1, 1,5,77, 8'h20,0,1);
    tv[16] = mk(0,0,0,  1,5,99, 0,0, 1, 1,5,99, 8'h00,0,0);
    tv[17] = mk(0,0,0,  0,0,0,  0,0, 1, 0,5,99, 8'h00,0,0);
    // scoreboard set/clear interactions
    tv[18] = mk(0,0,0,  0,0,0,  1,4, 1, 0,5,99, 8'h10,0,0);
    tv[19] = mk(0,0,0,  1,4,44, 1,4, 1, 1,4,44, 8'h10,0,0);
    tv[20] = mk(0,0,0,  1,4,45, 1,1, 1, 1,4,45, 8'h02,0,0);
    tv[21] = mk(1,3,33, 0,0,0,  1,3, 1, 1,3,33, 8'h0A,0,1);
    tv[22] = mk(0,0,0,  1,1,11, 0,0, 1, 1,1,11, 8'h08,0,0);
    tv[23] = mk(0,0,0,  1,3,13, 0,0, 1, 1,3,13, 8'h00,0,0);

    idle_in();
    Reset = 1'b1;
    #2;
    chk_zero("rst");
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 24; i++) apply(tv[i], i);

    chk("rf5", 32'(rf[5]), 99);
    chk("rf6", 32'(rf[6]), 60);
    chk("rf7", 32'(rf[7]), 15);

    // fill FIFO behind loads, then reset mid-cycle
    bus.MemValid = 1'b1;
    bus.MemAddr  = 3'd0;
    bus.MemData  = 8'd5;
    bus.AluValid = 1'b1;
    bus.AluAddr  = 3'd2;
    bus.AluData  = 8'd20;
    bus.LdIssue  = 1'b1;
    bus.LdAddr   = 3'd6;
    @(posedge Clk);
    #1;
    bus.LdIssue  = 1'b0;
    bus.MemData  = 8'd6;
    bus.AluAddr  = 3'd3;
    bus.AluData  = 8'd30;
    @(posedge Clk);
    #1;
    chk("fill.AluCount", 32'(bus.AluCount), 2);
    chk("fill.Pending", 32'(bus.Pending), 32'h40);
    chk("fill.WriteEn", 32'(bus.WriteEn), 1);
    idle_in();
    #2;
    Reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge Clk);
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("post%0d.AluReady", c),
          32'(bus.AluReady), 1);
      @(posedge Clk);
      #1;
      chk($sformatf("post%0d.WriteEn", c),
          32'(bus.WriteEn), 0);
      chk($sformatf("post%0d.AluCount", c),
          32'(bus.AluCount), 0);
    end
    chk("rf2", 32'(rf[2]), 3);
    chk("rf3", 32'(rf[3]), 13);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
